// File: rtl/itch_tx_pkg.sv
// Shared types and constants for the ITCH Add/Executed/Delete message transmitter.
// Covers message codes and lengths, timestamp width, and the optional length-prefix size.
package itch_tx_pkg;

  localparam int TS_W          = 48;
  localparam int TRK_W         = 16;
  localparam int LEN_PFX_W     = 16;
  localparam int LEN_PFX_BYTES = LEN_PFX_W / 8;

  localparam int LEN_ADD  = 36;
  localparam int LEN_EXEC = 31;
  localparam int LEN_DEL  = 19;

  // The largest message body plus the length prefix sets the shifter depth.
  localparam int MSG_BODY_W = LEN_ADD * 8;
  localparam int MAX_BYTES  = LEN_ADD + LEN_PFX_BYTES;
  localparam int CNT_W      = 6;

  localparam logic [7:0] CODE_ADD  = 8'h41;
  localparam logic [7:0] CODE_EXEC = 8'h45;
  localparam logic [7:0] CODE_DEL  = 8'h44;
  localparam logic [7:0] SIDE_BUY  = 8'h42;
  localparam logic [7:0] SIDE_SELL = 8'h53;

  typedef enum logic [1:0] {
    MSG_NONE,
    MSG_ADD,
    MSG_EXEC,
    MSG_DEL
  } msg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  function automatic logic [CNT_W-1:0] msg_len(input msg_t t);
    case (t)
      MSG_ADD:  return CNT_W'(LEN_ADD);
      MSG_EXEC: return CNT_W'(LEN_EXEC);
      MSG_DEL:  return CNT_W'(LEN_DEL);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/itch_tx_shifter.sv
// Byte serializer: loads a left-aligned message image, then presents one byte per
// cycle MSB-first while a down-counter tracks how many bytes remain.
module itch_tx_shifter
  import itch_tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic [MAX_BYTES*8-1:0] i_vec,
  input  logic [CNT_W-1:0]       i_cnt,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  output logic                   o_last
);

  logic [MAX_BYTES*8-1:0] r_buf;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_cnt;
      r_last <= (i_cnt == CNT_W'(1));
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_last <= (r_cnt == CNT_W'(2));
    end
  end

  // NOTE: the byte buffer is deliberately not reset; o_data is gated by o_valid,
  // so stale contents never reach the port and the wide register stays reset-free.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_buf <= i_vec;
    end else if (r_cnt != '0) begin
      r_buf <= {r_buf[MAX_BYTES*8-9:0], 8'h00};
    end
  end

  assign o_valid = (r_cnt != '0);
  assign o_last  = r_last;
  assign o_data  = o_valid ? r_buf[MAX_BYTES*8-1 -: 8] : 8'h00;

endmodule

// File: rtl/itch_msg_tx.sv
// ITCH message transmitter: arbitrates Add/Executed/Delete requests and streams one
// big-endian message per accept. Define ITCH_TX_MOLD_LEN_EN to prefix a 2-byte length.
module itch_msg_tx
  import itch_tx_pkg::*;
#(
  parameter logic [63:0] STOCK = 64'h2020202020202020,
  parameter int unsigned GAP   = 0
)(
  input  logic        clk,
  input  logic        rstN,
  input  logic        addValid,
  output logic        addReady,
  input  logic [15:0] addLocate,
  input  logic [63:0] addRefNum,
  input  logic        addBuySell,
  input  logic [31:0] addShares,
  input  logic [31:0] addPrice,
  input  logic        execValid,
  output logic        execReady,
  input  logic [15:0] execLocate,
  input  logic [63:0] execRefNum,
  input  logic        delValid,
  output logic        delReady,
  input  logic [15:0] delLocate,
  input  logic [63:0] delRefNum,
  output logic [7:0]  data,
  output logic        dataValid,
  output logic        dataLast
);

  localparam int unsigned GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  state_t                 r_state;
  logic [31:0]            r_gap_cnt;
  logic [TRK_W-1:0]       r_trk;
  logic [TS_W-1:0]        r_ts;

  msg_t                   w_sel;
  logic                   w_idle;
  logic                   w_accept;
  logic [MSG_BODY_W-1:0]  w_body;
  logic [CNT_W-1:0]       w_len;
  logic [CNT_W-1:0]       w_cnt;
  logic [MAX_BYTES*8-1:0] w_vec;
  logic [7:0]             w_sh_data;
  logic                   w_sh_valid;
  logic                   w_sh_last;

  // Readies fall with reset too, not only once the state register has cleared.
  assign w_idle = (r_state == S_IDLE) && rstN;

  always_comb begin
    // NOTE: default first so every path assigns w_sel and no latch is inferred.
    w_sel = MSG_NONE;
    if (w_idle) begin
      if (addValid)       w_sel = MSG_ADD;
      else if (execValid) w_sel = MSG_EXEC;
      else if (delValid)  w_sel = MSG_DEL;
    end
  end

  assign addReady  = (w_sel == MSG_ADD);
  assign execReady = (w_sel == MSG_EXEC);
  assign delReady  = (w_sel == MSG_DEL);
  assign w_accept  = (w_sel != MSG_NONE);

  // Message image left-aligned in the body; unused tail bytes are zero.
  always_comb begin
    w_body = '0;
    case (w_sel)
      MSG_ADD: w_body = {CODE_ADD, addLocate, r_trk, r_ts, addRefNum,
                         (addBuySell ? SIDE_BUY : SIDE_SELL), addShares, STOCK, addPrice};
      MSG_EXEC: w_body = {CODE_EXEC, execLocate, r_trk, r_ts, execRefNum, 32'h0, 64'h0,
                          {(MSG_BODY_W - LEN_EXEC*8){1'b0}}};
      MSG_DEL: w_body = {CODE_DEL, delLocate, r_trk, r_ts, delRefNum,
                         {(MSG_BODY_W - LEN_DEL*8){1'b0}}};
      default: w_body = '0;
    endcase
  end

  assign w_len = msg_len(w_sel);

`ifdef ITCH_TX_MOLD_LEN_EN
  assign w_vec = {LEN_PFX_W'(w_len), w_body};
  assign w_cnt = w_len + CNT_W'(LEN_PFX_BYTES);
`else
  assign w_vec = {w_body, {LEN_PFX_W{1'b0}}};
  assign w_cnt = w_len;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_trk     <= '0;
      r_ts      <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SEND;
            r_trk   <= r_trk + TRK_W'(1);
          end
        end
        S_SEND: begin
          if (w_sh_last) begin
            if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_M1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) r_state <= S_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  itch_tx_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rstN),
    .i_load  (w_accept),
    .i_vec   (w_vec),
    .i_cnt   (w_cnt),
    .o_data  (w_sh_data),
    .o_valid (w_sh_valid),
    .o_last  (w_sh_last)
  );

  assign data      = w_sh_data;
  assign dataValid = w_sh_valid;
  assign dataLast  = w_sh_last;

endmodule

// File: tb/tb_itch_msg_tx.sv
// Self-checking bench for itch_msg_tx: a byte-list reference model built from the
// message layouts, plus directed corner cases and randomized request mixes.
`timescale 1ns/1ps
module tb_itch_msg_tx;

  localparam logic [63:0] TB_STOCK = 64'h4141504C20202020;
`ifdef ITCH_TX_MOLD_LEN_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        addValid = 1'b0, execValid = 1'b0, delValid = 1'b0;
  logic        addReady, execReady, delReady;
  logic [15:0] addLocate = '0, execLocate = '0, delLocate = '0;
  logic [63:0] addRefNum = '0, execRefNum = '0, delRefNum = '0;
  logic        addBuySell = 1'b0;
  logic [31:0] addShares = '0, addPrice = '0;
  logic [7:0]  data;
  logic        dataValid, dataLast;

  itch_msg_tx #(.STOCK(TB_STOCK), .GAP(0)) dut (
    .clk(clk), .rstN(rstN),
    .addValid(addValid), .addReady(addReady), .addLocate(addLocate),
    .addRefNum(addRefNum), .addBuySell(addBuySell), .addShares(addShares),
    .addPrice(addPrice),
    .execValid(execValid), .execReady(execReady), .execLocate(execLocate),
    .execRefNum(execRefNum),
    .delValid(delValid), .delReady(delReady), .delLocate(delLocate),
    .delRefNum(delRefNum),
    .data(data), .dataValid(dataValid), .dataLast(dataLast)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  longint     m_ts = 0;
  logic [15:0] m_trk = '0;
  bit         m_busy = 1'b0;
  int         n_acc = 0;
  longint     acc_q[$];
  longint     first_cyc = 0, last_cyc = 0;
  bit         have_last = 1'b0;
  int         gaps_q[$];
  int         trunc_len = -1;
  bit         keep_last_only = 1'b0;
  logic [7:0] exp_bytes[$], rx_bytes[$], cur[$], last_msg[$];
  int         exp_len[$], rx_len[$];
  logic [2:0] exp_rdy;

  // Free-running cycle count since reset release equals the expected timestamp.
  initial forever begin
    @(posedge clk or negedge rstN);
    if (!rstN) m_ts = 0;
    else if (clk) m_ts = m_ts + 1;
  end

  function automatic void push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(v[i*8 +: 8]);
  endfunction

  function automatic void build_msg(input logic [7:0] code, input logic [15:0] loc,
                                    input logic [63:0] refn, input bit side,
                                    input logic [31:0] shares, input logic [31:0] price);
    int len;
    len = (code == 8'h41) ? 36 : (code == 8'h45) ? 31 : 19;
    if (keep_last_only) begin
      exp_bytes.delete();
      exp_len.delete();
    end
`ifdef ITCH_TX_MOLD_LEN_EN
    push_be(64'(len), 2);
`endif
    push_be(64'(code), 1);
    push_be(64'(loc), 2);
    push_be(64'(m_trk), 2);
    push_be(m_ts, 6);
    push_be(refn, 8);
    if (code == 8'h41) begin
      push_be(side ? 64'h42 : 64'h53, 1);
      push_be(64'(shares), 4);
      push_be(TB_STOCK, 8);
      push_be(64'(price), 4);
    end else if (code == 8'h45) begin
      push_be(64'h0, 4);
      push_be(64'h0, 8);
    end
    exp_len.push_back(len + PFX);
  endfunction

  // Negedge monitor: arbitration rule, idle-output rule, byte capture, accept capture.
  initial forever begin
    @(negedge clk);
    if (!rstN) begin
      check("rst_ready", {addReady, execReady, delReady}, 3'b000);
      check("rst_out", {dataValid, dataLast, data}, 10'h000);
      if (cur.size() != 0) trunc_len = cur.size();
      cur.delete();
      m_trk = '0;
      m_busy = 1'b0;
      have_last = 1'b0;
    end else begin
      exp_rdy = 3'b000;
      if (!m_busy) begin
        if (addValid)       exp_rdy = 3'b100;
        else if (execValid) exp_rdy = 3'b010;
        else if (delValid)  exp_rdy = 3'b001;
      end
      check("ready", {addReady, execReady, delReady}, exp_rdy);
      if (dataValid) begin
        if (cur.size() == 0) begin
          first_cyc = m_ts;
          if (have_last) gaps_q.push_back(int'(m_ts - last_cyc - 1));
        end
        cur.push_back(data);
        if (dataLast) begin
          if (keep_last_only) begin
            rx_bytes.delete();
            rx_len.delete();
          end
          foreach (cur[i]) rx_bytes.push_back(cur[i]);
          rx_len.push_back(cur.size());
          cur.delete();
          last_cyc = m_ts;
          have_last = 1'b1;
          m_busy = 1'b0;
        end
      end else begin
        check("idle_out", {dataLast, data}, 9'h000);
      end
      if (addValid && addReady)
        build_msg(8'h41, addLocate, addRefNum, addBuySell, addShares, addPrice);
      else if (execValid && execReady)
        build_msg(8'h45, execLocate, execRefNum, 1'b0, 32'h0, 32'h0);
      else if (delValid && delReady)
        build_msg(8'h44, delLocate, delRefNum, 1'b0, 32'h0, 32'h0);
      if ((addValid && addReady) || (execValid && execReady) || (delValid && delReady)) begin
        acc_q.push_back(m_ts);
        n_acc++;
        m_trk = m_trk + 16'd1;
        m_busy = 1'b1;
      end
    end
  end

  task automatic rand_fields();
    addLocate  = 16'($urandom);
    addRefNum  = {$urandom, $urandom};
    addBuySell = 1'($urandom_range(0, 1));
    addShares  = $urandom;
    addPrice   = $urandom;
    execLocate = 16'($urandom);
    execRefNum = {$urandom, $urandom};
    delLocate  = 16'($urandom);
    delRefNum  = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstN = 1'b0;
    addValid = 1'b0; execValid = 1'b0; delValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  // Raise the requested valids; drop each one after the edge that accepts it.
  task automatic issue(input bit a, input bit e, input bit d);
    bit ha, he, hd;
    @(posedge clk); #1;
    addValid = a; execValid = e; delValid = d;
    for (int c = 0; c < 400 && (addValid || execValid || delValid); c++) begin
      @(negedge clk);
      ha = addValid && addReady;
      he = execValid && execReady;
      hd = delValid && delReady;
      @(posedge clk); #1;
      if (ha) addValid = 1'b0;
      if (he) execValid = 1'b0;
      if (hd) delValid = 1'b0;
    end
    if (addValid || execValid || delValid) begin
      check("accept_timeout", {addValid, execValid, delValid}, 3'b000);
      addValid = 1'b0; execValid = 1'b0; delValid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while ((m_busy || dataValid) && c < 200);
    if (m_busy || dataValid) check("idle_timeout", {m_busy, dataValid}, 2'b00);
  endtask

  task automatic cmp_msg(input string tag);
    int el, rl;
    logic [7:0] e;
    last_msg.delete();
    if (exp_len.size() == 0) return;
    el = exp_len.pop_front();
    check({tag, "_present"}, 64'(rx_len.size() != 0), 64'd1);
    if (rx_len.size() == 0) begin
      for (int i = 0; i < el; i++) void'(exp_bytes.pop_front());
      return;
    end
    rl = rx_len.pop_front();
    check({tag, "_len"}, 64'(rl), 64'(el));
    for (int i = 0; i < rl; i++) last_msg.push_back(rx_bytes.pop_front());
    for (int i = 0; i < el; i++) begin
      e = exp_bytes.pop_front();
      if (i < rl) check($sformatf("%s_b%0d", tag, i), last_msg[i], e);
    end
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with every request line asserted
    addValid = 1'b1; execValid = 1'b1; delValid = 1'b1;
    #2;
    check("rst_ready0", {addReady, execReady, delReady}, 3'b000);
    check("rst_out0", {dataValid, dataLast, data}, 10'h000);
    addValid = 1'b0; execValid = 1'b0; delValid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // Directed Add: latency, length, type and side bytes
    addLocate = 16'h0001; addRefNum = 64'h10; addBuySell = 1'b1;
    addShares = 32'd100; addPrice = 32'h2710;
    acc_q.delete();
    issue(1'b1, 1'b0, 1'b0);
    wait_idle();
    check("add_first_lat", 64'(first_cyc - acc_q[$]), 64'd1);
    check("add_last_lat", 64'(last_cyc - acc_q[$]), 64'(36 + PFX));
    cmp_msg("add");
    check("add_b0", last_msg[PFX], 8'h41);
    check("add_b19", last_msg[PFX + 19], 8'h42);

    // A valid raised and dropped while busy is never accepted
    rand_fields();
    issue(1'b1, 1'b0, 1'b0);
    execValid = 1'b1;
    repeat (5) @(posedge clk);
    #1 execValid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    #1 check("drop_cnt", 64'(rx_len.size()), 64'd1);
    cmp_msg("drop_add");

    // All three at once: priority order, tracking 0/1/2, one idle cycle between
    do_reset();
    rand_fields();
    gaps_q.delete();
    issue(1'b1, 1'b1, 1'b1);
    wait_idle();
    check("prio_cnt", 64'(rx_len.size()), 64'd3);
    cmp_msg("prio_add");
    check("prio_add_type", last_msg[PFX], 8'h41);
    check("prio_add_trk", {last_msg[PFX + 3], last_msg[PFX + 4]}, 16'd0);
    cmp_msg("prio_exec");
    check("prio_exec_type", last_msg[PFX], 8'h45);
    check("prio_exec_trk", {last_msg[PFX + 3], last_msg[PFX + 4]}, 16'd1);
    cmp_msg("prio_del");
    check("prio_del_type", last_msg[PFX], 8'h44);
    check("prio_del_trk", {last_msg[PFX + 3], last_msg[PFX + 4]}, 16'd2);
    check("prio_gap_cnt", 64'(gaps_q.size()), 64'd2);
    check("prio_gap0", 64'(gaps_q[0]), 64'd1);
    check("prio_gap1", 64'(gaps_q[1]), 64'd1);

    // Delete held through an Add waits for idle
    rand_fields();
    acc_q.delete();
    issue(1'b1, 1'b0, 1'b1);
    wait_idle();
    check("hold_cnt", 64'(rx_len.size()), 64'd2);
    check("hold_acc_gap", 64'(acc_q[$] - acc_q[0]), 64'(37 + PFX));
    cmp_msg("hold_add");
    cmp_msg("hold_del");
    check("hold_del_len", 64'(last_msg.size()), 64'(19 + PFX));
    check("hold_del_b0", last_msg[PFX], 8'h44);

    // Executed layout, including the optional length prefix
    rand_fields();
    issue(1'b0, 1'b1, 1'b0);
    wait_idle();
    cmp_msg("exec");
    check("exec_len", 64'(last_msg.size()), 64'(31 + PFX));
`ifdef ITCH_TX_MOLD_LEN_EN
    check("exec_pfx0", last_msg[0], 8'h00);
    check("exec_pfx1", last_msg[1], 8'h1F);
    check("exec_b0", last_msg[2], 8'h45);
`else
    check("exec_b0", last_msg[0], 8'h45);
`endif

    // Randomized request mixes
    for (int it = 0; it < 40; it++) begin
      rand_fields();
      begin
        int mask;
        mask = $urandom_range(1, 7);
        issue(mask[2], mask[1], mask[0]);
      end
      wait_idle();
      check($sformatf("rand%0d_cnt", it), 64'(rx_len.size()), 64'(exp_len.size()));
      while (exp_len.size() > 0) cmp_msg($sformatf("rand%0d", it));
    end

    // Reset in the middle of an Add
    rand_fields();
    trunc_len = -1;
    issue(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 100 && cur.size() < 10; c++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    check("rst_mid_dv", dataValid, 1'b0);
    check("rst_mid_last", dataLast, 1'b0);
    check("rst_mid_data", data, 8'h00);
    repeat (2) @(posedge clk);
    check("rst_mid_trunc", 64'(trunc_len), 64'd10);
    check("rst_mid_nomsg", 64'(rx_len.size()), 64'd0);
    exp_bytes.delete();
    exp_len.delete();
    #1 rstN = 1'b1;
    rand_fields();
    issue(1'b0, 1'b0, 1'b1);
    wait_idle();
    cmp_msg("post_rst");
    check("post_rst_trk", {last_msg[PFX + 3], last_msg[PFX + 4]}, 16'd0);

    // Tracking wrap after 65537 Deletes from reset
    do_reset();
    rand_fields();
    keep_last_only = 1'b1;
    n_acc = 0;
    acc_q.delete();
    @(posedge clk); #1;
    delValid = 1'b1;
    for (int c = 0; c < 1_400_000 && n_acc < 65537; c++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    delValid = 1'b0;
    check("wrap_acc", 64'(n_acc), 64'd65537);
    wait_idle();
    keep_last_only = 1'b0;
    cmp_msg("wrap");
    check("wrap_trk", {last_msg[PFX + 3], last_msg[PFX + 4]}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
